// File: rtl/if_id_queue.sv
// Decoupling queue between instruction fetch and decode: a small circular
// buffer of {instruction, PC} pairs with valid/ready on both sides and a flush.
module if_id_queue #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [31:0]              if_inst,
    input  logic [PC_W-1:0]          if_pc,
    output logic                     if_id_ready,
    input  logic                     flush,
    output logic                     id_valid,
    output logic [31:0]              id_inst,
    output logic [PC_W-1:0]          id_pc,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [31:0]     inst_q [DEPTH];
    logic [PC_W-1:0] pc_q   [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;

    // Ready depends only on registered occupancy, so id_ready never reaches it.
    assign if_id_ready = (count_q != CW'(DEPTH));
    assign id_valid    = (count_q != '0);
    assign count       = count_q;

    assign push = if_valid & if_id_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    assign id_inst = id_valid ? inst_q[rd_ptr] : NOP_INST;
    assign id_pc   = id_valid ? pc_q[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Flush leaves storage untouched; only the pointers and count are cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            inst_q[wr_ptr] <= if_inst;
            pc_q[wr_ptr]   <= if_pc;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a queue-based reference model checked
// every cycle, plus directed sequences with literal expected values.
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_id_ready;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [$clog2(DEPTH):0] count;

    int checks;
    int failures;

    logic [31:0] model_inst[$];
    logic [31:0] model_pc[$];

    if_id_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk),
        .rst(rst),
        .if_valid(if_valid),
        .if_inst(if_inst),
        .if_pc(if_pc),
        .if_id_ready(if_id_ready),
        .flush(flush),
        .id_valid(id_valid),
        .id_inst(id_inst),
        .id_pc(id_pc),
        .id_ready(id_ready),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic rdy, input logic fl);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
        id_ready = rdy;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of at most DEPTH entries, flush empties it and drops the push.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_inst.delete();
            model_pc.delete();
        end else if (flush) begin
            model_inst.delete();
            model_pc.delete();
        end else begin
            bit do_push;
            bit do_pop;
            do_push = if_valid && (model_inst.size() < DEPTH);
            do_pop  = (model_inst.size() != 0) && id_ready;
            if (do_pop) begin
                void'(model_inst.pop_front());
                void'(model_pc.pop_front());
            end
            if (do_push) begin
                model_inst.push_back(if_inst);
                model_pc.push_back(if_pc);
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        e_inst = (model_inst.size() != 0) ? model_inst[0] : NOP;
        e_pc   = (model_pc.size() != 0) ? model_pc[0] : 32'h0;
        checkOutput("model id_valid", 32'(id_valid), 32'(model_inst.size() != 0));
        checkOutput("model id_inst", id_inst, e_inst);
        checkOutput("model id_pc", id_pc, e_pc);
        checkOutput("model count", 32'(count), 32'(model_inst.size()));
        checkOutput("model if_id_ready", 32'(if_id_ready), 32'(model_inst.size() < DEPTH));
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        checkOutput("reset id_valid", 32'(id_valid), 32'd0);
        checkOutput("reset id_inst", id_inst, NOP);
        checkOutput("reset id_pc", id_pc, 32'h0);
        checkOutput("reset if_id_ready", 32'(if_id_ready), 32'd1);
        checkOutput("reset count", 32'(count), 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Fill to full with decode stalled, then drain.
        applyStimulus(1'b1, 32'h00500093, 32'h80000000, 1'b0, 1'b0);
        tick();
        checkOutput("fill count1", 32'(count), 32'd1);
        checkOutput("fill head inst", id_inst, 32'h00500093);
        checkOutput("fill id_valid", 32'(id_valid), 32'd1);
        applyStimulus(1'b1, 32'h00100113, 32'h80000004, 1'b0, 1'b0);
        tick();
        checkOutput("fill count2", 32'(count), 32'd2);
        checkOutput("fill full ready", 32'(if_id_ready), 32'd0);
        checkOutput("fill head held", id_inst, 32'h00500093);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("drain pc0", id_pc, 32'h80000000);
        tick();
        checkOutput("drain pc1", id_pc, 32'h80000004);
        checkOutput("drain count1", 32'(count), 32'd1);
        tick();
        checkOutput("drain count0", 32'(count), 32'd0);
        checkOutput("drain nop", id_inst, NOP);
        checkOutput("drain id_valid", 32'(id_valid), 32'd0);

        // Full with simultaneous pop: only the pop happens.
        applyStimulus(1'b1, 32'h11111111, 32'h80000100, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h22222222, 32'h80000104, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h33333333, 32'h80000108, 1'b1, 1'b0);
        checkOutput("fullpop ready low", 32'(if_id_ready), 32'd0);
        tick();
        checkOutput("fullpop count", 32'(count), 32'd1);
        checkOutput("fullpop head", id_pc, 32'h80000104);
        checkOutput("fullpop ready back", 32'(if_id_ready), 32'd1);
        applyStimulus(1'b1, 32'h33333333, 32'h80000108, 1'b0, 1'b0);
        tick();
        checkOutput("fullpop push count", 32'(count), 32'd2);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("fullpop tail", id_pc, 32'h80000108);
        tick();
        checkOutput("fullpop empty", 32'(count), 32'd0);

        // Streaming: one push and one pop per cycle across many wraps.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'hA0000000 + 32'(i), 32'h80000000 + 32'(4 * i), 1'b1, 1'b0);
            if (i > 0) begin
                checkOutput("stream pc", id_pc, 32'h80000000 + 32'(4 * (i - 1)));
                checkOutput("stream count", 32'(count), 32'd1);
            end
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("stream last pc", id_pc, 32'h8000003C);
        tick();
        checkOutput("stream empty", 32'(count), 32'd0);

        // Flush when full and when partially filled; the presented push is dropped.
        applyStimulus(1'b1, 32'h44444444, 32'h80000200, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h55555555, 32'h80000204, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h66666666, 32'h80000208, 1'b0, 1'b1);
        checkOutput("flush full ready", 32'(if_id_ready), 32'd0);
        tick();
        checkOutput("flush full count", 32'(count), 32'd0);
        checkOutput("flush full valid", 32'(id_valid), 32'd0);
        applyStimulus(1'b1, 32'h77777777, 32'h8000020C, 1'b0, 1'b0);
        tick();
        checkOutput("flush refill", 32'(count), 32'd1);
        applyStimulus(1'b1, 32'h88888888, 32'h80000210, 1'b0, 1'b1);
        checkOutput("flush part ready", 32'(if_id_ready), 32'd1);
        tick();
        checkOutput("flush part count", 32'(count), 32'd0);
        checkOutput("flush part valid", 32'(id_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("flush no ghost", 32'(count), 32'd0);
        applyStimulus(1'b1, 32'h99999999, 32'h80000214, 1'b0, 1'b0);
        tick();
        checkOutput("flush after pc", id_pc, 32'h80000214);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Asynchronous reset between edges.
        applyStimulus(1'b1, 32'hAAAAAAAA, 32'h80000300, 1'b0, 1'b0);
        tick();
        checkOutput("areset pre count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("areset id_valid", 32'(id_valid), 32'd0);
        checkOutput("areset count", 32'(count), 32'd0);
        checkOutput("areset id_inst", id_inst, NOP);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 32'hBBBBBBBB, 32'h80000304, 1'b0, 1'b0);
        tick();
        checkOutput("areset first pc", id_pc, 32'h80000304);
        checkOutput("areset first count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Backpressure: head stays stable while fetch toggles.
        applyStimulus(1'b1, 32'hCCCC0000, 32'h80000400, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i % 2 == 0, 32'hDDDD0000 + 32'(i), 32'h80000404 + 32'(4 * i), 1'b0, 1'b0);
            tick();
            checkOutput("bp inst", id_inst, 32'hCCCC0000);
            checkOutput("bp pc", id_pc, 32'h80000400);
            checkOutput("bp count", 32'(count), 32'd2);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("bp second pc", id_pc, 32'h80000404);
        checkOutput("bp second inst", id_inst, 32'hDDDD0000);
        tick();
        checkOutput("bp drained", 32'(count), 32'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decoupling queue between the instruction fetch unit and the instruction decode unit. It accepts each fetched instruction with its PC from the IFU valid/ready handshake and stores it in a small circular buffer. It presents the oldest entry to decode through its own valid/ready handshake. A redirect from execute flushes all wrong-path entries.

## Interface
- DEPTH, 2, number of entries; power of two, ≥ 2
- PC_W, 32, PC width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), release synchronous to clk
- if_valid  in  1  IFU holds a fetched instruction; stays high until accepted
- if_inst  in  32  fetched instruction word
- if_pc  in  PC_W  PC of if_inst
- if_id_ready  out  1  queue can accept; equals (count < DEPTH), a function of registered state only
- flush  in  1  redirect from execute; discard all contents and any same-cycle push
- id_valid  out  1  head entry valid; equals (count != 0)
- id_inst  out  32  head instruction; 32'h0000_0013 (NOP) when empty
- id_pc  out  PC_W  head PC; 0 when empty
- id_ready  in  1  decode accepts head this cycle
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State:
  - storage inst_q[DEPTH], pc_q[DEPTH]
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0
  - count register
- Definitions:
  - push = if_valid & if_id_ready & ~flush
  - pop = id_valid & id_ready & ~flush
- push: write {if_inst, if_pc} at wr_ptr, wr_ptr += 1
- pop: rd_ptr += 1
- count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- Simultaneous push and pop at non-full, non-empty occupancy:
  - both occur and count holds
  - the written slot never equals the read slot, because count is between 1 and DEPTH−1
- Full (count == DEPTH):
  - if_id_ready = 0, even if id_ready = 1 the same cycle
  - no combinational path from id_ready to if_id_ready
  - the pop frees a slot and if_id_ready rises next cycle
- Empty (count == 0):
  - id_valid = 0; id_ready is ignored
  - no bypass: a pushed entry is not visible the same cycle
- Flush (highest priority over push and pop):
  - next edge: count = 0, wr_ptr = rd_ptr = 0
  - storage is not cleared
  - the IFU instruction presented that cycle is dropped, even with if_id_ready = 1
- id_inst / id_pc: combinational read of inst_q[rd_ptr] / pc_q[rd_ptr], forced to NOP / 0 when count == 0
- if_valid low with stale if_inst/if_pc: no effect
- if_inst/if_pc are sampled only on push

## Timing
- Reset (rst = 0), asynchronous and immediate:
  - count = 0, wr_ptr = rd_ptr = 0, all storage = 0
  - outputs: id_valid = 0, id_inst = 32'h0000_0013, id_pc = 0, if_id_ready = 1
- Reset asserted mid-operation discards all entries; no partial push survives.
- Latency: push at edge N makes the entry visible (id_valid = 1) in the cycle after edge N, i.e. one cycle, provided the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- With DEPTH = 2, full-rate fetch and decode never stall each other.
- Handshake: a transfer occurs on the rising edge where valid & ready = 1.
  - Outputs may change only after an edge.
  - id_inst/id_pc stay stable while id_valid = 1 and id_ready = 0.
- Flush latency: contents are gone from the cycle after the flush edge; if_id_ready = 1 that cycle.

## Test plan
- Reset and basic fill/drain:
  - stimulus: release rst; push {inst 32'h00500093, pc 32'h80000000}, then {32'h00100113, 32'h80000004}, with id_ready = 0
  - required: count 1 then 2; if_id_ready = 0 at count 2; id_inst = 32'h00500093 held
  - then id_ready = 1 for 2 cycles: id_pc 80000000 then 80000004, count back to 0, id_inst = NOP
- Full with simultaneous pop: count = 2, if_valid = 1, id_ready = 1
  - required: pop only that cycle, count = 1
  - next cycle: if_id_ready = 1, push accepted, count = 2
- Streaming wrap-around: 16 consecutive PCs 80000000..8000003C, if_valid and id_ready held high
  - required: id_pc sequence in order with no gaps or duplicates
  - pointers wrap at least 4 times; count steady at 1 after the first push
- Flush with pending push: count = 2, flush = 1 and if_valid = 1 (if_id_ready = 0), then flush = 1 again at count 1 with if_id_ready = 1
  - required: next cycle count = 0, id_valid = 0
  - the presented instruction is not enqueued in either case
- Async reset mid-stream: assert rst between edges at count = 1
  - required: id_valid = 0 and count = 0 immediately, without waiting for a clock edge
  - first push after release appears with the correct pc
- Backpressure stability: count = 1, id_ready = 0 for 5 cycles while if_valid toggles
  - required: id_inst/id_pc constant and only one additional push accepted
  - count = 2 thereafter
